// File: rtl/thresh_presets_sequencer.sv
// Preset sequencer: next/prev buttons step through up to 16 threshold/timer presets,
// presenting the active preset live and offering each new selection over valid/ready.
module thresh_presets_sequencer #(
    parameter int N_PRESETS   = 10,
    parameter int VAL_W       = 16,
    parameter int DEFAULT_IDX = 0,
    parameter int WRAP_EN     = 1,
    parameter logic [16*VAL_W-1:0] PRESET_THRESHOLDS = {16{VAL_W'(65000)}},
    parameter logic [16*VAL_W-1:0] PRESET_TIMERS     = {16{VAL_W'(65000)}}
) (
    input  logic             i_clk_20mhz,
    input  logic             i_rstn_20mhz,
    input  logic             i_btn_next,
    input  logic             i_btn_prev,
    output logic [3:0]       o_value_enum,
    output logic [VAL_W-1:0] o_value_thresh,
    output logic [VAL_W-1:0] o_value_timer,
    output logic             o_upd_valid,
    input  logic             i_upd_ready,
    output logic [3:0]       o_upd_enum,
    output logic [VAL_W-1:0] o_upd_thresh,
    output logic [VAL_W-1:0] o_upd_timer
);

    localparam logic [3:0] LAST_IDX = 4'(N_PRESETS - 1);
    localparam logic [3:0] DEF_IDX  = 4'(DEFAULT_IDX);

    // Entry 0 sits in the MSBs of each packed table.
    function automatic logic [VAL_W-1:0] thresh_of(input logic [3:0] k);
        return PRESET_THRESHOLDS[(16 - int'(k))*VAL_W-1 -: VAL_W];
    endfunction

    function automatic logic [VAL_W-1:0] timer_of(input logic [3:0] k);
        return PRESET_TIMERS[(16 - int'(k))*VAL_W-1 -: VAL_W];
    endfunction

    logic [3:0] idx_nxt;
    logic       changed;
    logic       accept;
    logic       offer;
    logic       pending;

    // o_value_enum doubles as the index register.
    always_comb begin
        idx_nxt = o_value_enum;
        if (i_btn_next && !i_btn_prev) begin
            if (o_value_enum != LAST_IDX)
                idx_nxt = o_value_enum + 4'd1;
            else if (WRAP_EN != 0)
                idx_nxt = 4'd0;
        end else if (i_btn_prev && !i_btn_next) begin
            if (o_value_enum != 4'd0)
                idx_nxt = o_value_enum - 4'd1;
            else if (WRAP_EN != 0)
                idx_nxt = LAST_IDX;
        end
    end

    assign changed = (idx_nxt != o_value_enum);
    assign accept  = o_upd_valid && i_upd_ready;
    assign offer   = (!o_upd_valid || accept) && (changed || pending);

    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rstn_20mhz) begin
            o_value_enum   <= DEF_IDX;
            o_value_thresh <= thresh_of(DEF_IDX);
            o_value_timer  <= timer_of(DEF_IDX);
            o_upd_valid    <= 1'b0;
            o_upd_enum     <= DEF_IDX;
            o_upd_thresh   <= thresh_of(DEF_IDX);
            o_upd_timer    <= timer_of(DEF_IDX);
            pending        <= 1'b1;
        end else begin
            o_value_enum   <= idx_nxt;
            o_value_thresh <= thresh_of(idx_nxt);
            o_value_timer  <= timer_of(idx_nxt);
            if (offer) begin
                o_upd_valid  <= 1'b1;
                o_upd_enum   <= idx_nxt;
                o_upd_thresh <= thresh_of(idx_nxt);
                o_upd_timer  <= timer_of(idx_nxt);
                pending      <= 1'b0;
            end else begin
                // Payload stays frozen while an offer is outstanding; later moves collapse.
                if (accept)
                    o_upd_valid <= 1'b0;
                if (changed)
                    pending <= 1'b1;
            end
        end
    end

endmodule
